// File: rtl/instr_fetch_seq.sv
// Instruction fetch and step sequencer: fetches a 16-bit word over a req/ack
// handshake, then steps the control unit through four execution steps.
module instr_fetch_seq #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  input  logic          pc_enable,
  input  logic          pc_load,
  input  logic          halt,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   instrucao,
  output logic [1:0]    step,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic [15:0]   retired
);

  localparam int OW = (AW > 10) ? AW : 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [15:0]   r_ir;
  logic [1:0]    r_step;
  logic [15:0]   r_retired;

  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [15:0]   w_ir_nxt;
  logic [1:0]    w_step_nxt;
  logic [15:0]   w_retired_nxt;
  logic [OW-1:0] w_off_ext;
  logic [AW-1:0] w_branch_pc;

  // Branch offset is a signed 10-bit field; the sum wraps modulo 2^AW.
  assign w_off_ext   = OW'($signed(r_ir[9:0]));
  assign w_branch_pc = r_pc + w_off_ext[AW-1:0];

  // NOTE: every variable gets a default before the case, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_step_nxt    = r_step;
    w_retired_nxt = r_retired;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          w_ir_nxt    = mem_rdata;
          w_step_nxt  = 2'd0;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // Halt freezes pc/ir/step and takes priority over a step-3 update.
        if (halt) begin
          w_state_nxt = S_HALTED;
        end else if (r_step == 2'd3) begin
          w_state_nxt = S_FETCH;
          if (pc_enable) begin
            w_pc_nxt      = pc_load ? w_branch_pc : r_pc + AW'(1);
            w_retired_nxt = (r_retired == 16'hFFFF) ? r_retired : r_retired + 16'd1;
          end
        end else begin
          w_step_nxt = r_step + 2'd1;
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and all state
  // uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= 16'h0000;
      r_step    <= 2'd0;
      r_retired <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_ir      <= w_ir_nxt;
      r_step    <= w_step_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  assign mem_req   = (r_state == S_FETCH);
  assign mem_addr  = r_pc;
  assign instrucao = r_ir;
  assign step      = r_step;
  assign pc        = r_pc;
  assign halted    = (r_state == S_HALTED);
  assign retired   = r_retired;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Table-driven bench for instr_fetch_seq: each record is one clock cycle of
// inputs plus the outputs expected to be visible during that cycle.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pc_enable;
  logic        pc_load;
  logic        halt;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] instrucao;
  logic [1:0]  step;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  instr_fetch_seq #(.AW(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pc_enable (pc_enable),
    .pc_load   (pc_load),
    .halt      (halt),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .instrucao (instrucao),
    .step      (step),
    .pc        (pc),
    .halted    (halted),
    .retired   (retired)
  );

  typedef struct {
    logic        rst_n;
    logic        ack;
    logic [15:0] rdata;
    logic        en;
    logic        ld;
    logic        hlt;
    logic        req;
    logic [7:0]  addr;
    logic [15:0] ir;
    logic [1:0]  step;
    logic        halted;
    logic [15:0] ret;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] e_ir;
  logic [1:0]  e_step;
  logic [15:0] e_ret;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic add(input logic rst_n, input logic ack, input logic [15:0] rdata,
                     input logic en, input logic ld, input logic hlt,
                     input logic req, input logic [7:0] addr, input logic [1:0] stp,
                     input logic hltd);
    vec_t v;
    v.rst_n = rst_n; v.ack = ack; v.rdata = rdata;
    v.en = en; v.ld = ld; v.hlt = hlt;
    v.req = req; v.addr = addr; v.ir = e_ir; v.step = stp;
    v.halted = hltd; v.ret = e_ret;
    vq.push_back(v);
  endtask

  // IDLE cycle right after a reset edge; control inputs and ack must be ignored.
  task automatic idle(input logic ack);
    e_ir = 16'h0000; e_step = 2'd0; e_ret = 16'h0000;
    add(1'b1, ack, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0, 1'b0);
  endtask

  // One instruction at address a: wait cycles, ack cycle, then EXEC steps 0..3.
  // Control inputs are held through every EXEC step; only step 3 may use them.
  task automatic instr(input logic [7:0] a, input logic [15:0] word, input int waits,
                       input logic en, input logic ld, input int stray,
                       input int halt_step, input int abort_step);
    for (int w = 0; w < waits; w++)
      add(1'b1, 1'b0, 16'h5A5A, 1'b1, 1'b1, 1'b1, 1'b1, a, e_step, 1'b0);
    add(1'b1, 1'b1, word, 1'b0, 1'b0, 1'b0, 1'b1, a, e_step, 1'b0);
    e_ir = word;
    for (int s = 0; s < 4; s++) begin
      if (s == abort_step) begin
        add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, a, 2'(s), 1'b0);
        return;
      end
      add(1'b1, (s == stray), 16'hDEAD, en, ld, (s == halt_step), 1'b0, a, 2'(s), 1'b0);
      if (s == halt_step) begin
        e_step = 2'(s);
        return;
      end
    end
    e_step = 2'd3;
    if (en) e_ret = e_ret + 16'd1;
  endtask

  // Cycles spent in HALTED with every input toggling; optionally reset on the last.
  task automatic halted_cycles(input int n, input logic [7:0] a, input logic rst_last);
    for (int i = 0; i < n; i++)
      add((rst_last && i == n - 1) ? 1'b0 : 1'b1, i[0], 16'hF00D,
          1'b1, 1'b1, 1'b1, 1'b0, a, e_step, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    pc_enable = 1'b0; pc_load = 1'b0; halt = 1'b0;

    // Program 1: sequential ADDs, branches, wraps, stalls, refetch, halt.
    idle(1'b1);
    instr(8'd0,   16'h0001, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd1,   16'h0002, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd2,   16'h0003, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd3,   16'hA002, 0, 1'b1, 1'b1, -1, -1, -1);  // +2 -> 5
    instr(8'd5,   16'hA003, 3, 1'b1, 1'b1,  1, -1, -1);  // 3 waits, stray ack, +3 -> 8
    instr(8'd8,   16'hA3FC, 0, 1'b1, 1'b1, -1, -1, -1);  // -4 -> 4
    instr(8'd4,   16'hA0FA, 0, 1'b1, 1'b1, -1, -1, -1);  // +250 -> 254
    instr(8'd254, 16'hA003, 0, 1'b1, 1'b1, -1, -1, -1);  // +3 wraps -> 1
    instr(8'd1,   16'hA0FE, 0, 1'b1, 1'b1, -1, -1, -1);  // +254 -> 255
    instr(8'd255, 16'h0000, 0, 1'b1, 1'b0, -1, -1, -1);  // increment wraps -> 0
    instr(8'd0,   16'h1234, 0, 1'b0, 1'b1, -1, -1, -1);  // no pc_enable: refetch 0
    instr(8'd0,   16'hA000, 0, 1'b1, 1'b1, -1, -1, -1);  // offset 0 self-loop
    instr(8'd0,   16'hA006, 0, 1'b1, 1'b1, -1, -1, -1);  // +6 -> 6
    instr(8'd6,   16'hE000, 0, 1'b1, 1'b1, -1,  0, -1);  // HLT at step 0
    halted_cycles(4, 8'd6, 1'b1);

    // Program 2: reset during step 2, then halt racing pc_enable at step 3.
    idle(1'b0);
    instr(8'd0,   16'h0001, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd1,   16'h0005, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd2,   16'h0009, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd3,   16'h4321, 0, 1'b1, 1'b0, -1, -1,  2);  // reset at step 2
    idle(1'b1);
    instr(8'd0,   16'h0001, 0, 1'b1, 1'b0, -1, -1, -1);
    instr(8'd1,   16'h0777, 0, 1'b1, 1'b0, -1,  3, -1);  // halt wins over pc_enable
    halted_cycles(3, 8'd1, 1'b0);

    repeat (2) @(posedge clk);
    #1;

    foreach (vq[i]) begin
      resetn    = vq[i].rst_n;
      mem_ack   = vq[i].ack;
      mem_rdata = vq[i].rdata;
      pc_enable = vq[i].en;
      pc_load   = vq[i].ld;
      halt      = vq[i].hlt;
      check(i, vq[i]);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  task automatic check(input int idx, input vec_t v);
    n_vec++;
    if (mem_req !== v.req || mem_addr !== v.addr || pc !== v.addr ||
        instrucao !== v.ir || step !== v.step || halted !== v.halted ||
        retired !== v.ret) begin
      n_bad++;
      $display("FAIL vec%0d: got req=%0b addr=%0d pc=%0d ir=%h step=%0d halted=%0b ret=%0d | want req=%0b addr=%0d pc=%0d ir=%h step=%0d halted=%0b ret=%0d",
               idx, mem_req, mem_addr, pc, instrucao, step, halted, retired,
               v.req, v.addr, v.addr, v.ir, v.step, v.halted, v.ret);
    end
  endtask

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch and step sequencer for the 16-bit multicycle processor. It issues instruction reads to program memory over a req/ack handshake and latches each returned word into an instruction register. It then drives `instrucao` and the 2-bit `step` count into the control unit. It consumes the control unit's `pc_enable`, `pc_load` and `halt` to advance, branch or stop the program counter.

## Interface
- `AW`, default 8: program counter and memory address width.
- `clk  in  1`: clock; all state updates on the rising edge.
- `resetn  in  1`: reset, synchronous, active-low.
- `mem_ack  in  1`: memory read complete; `mem_rdata` is valid in this cycle.
- `mem_rdata  in  16`: instruction word from program memory.
- `pc_enable  in  1`: from control unit; PC update permitted, sampled only at step 3.
- `pc_load  in  1`: from control unit; 1 = load branch target, 0 = increment.
- `halt  in  1`: from control unit; HLT decoded.
- `mem_req  out  1`: read request; high for the whole FETCH state.
- `mem_addr  out  AW`: read address, equal to PC; stable while `mem_req` is high.
- `instrucao  out  16`: instruction register to control unit.
- `step  out  2`: execution step to control unit.
- `pc  out  AW`: current program counter.
- `halted  out  1`: processor stopped.
- `retired  out  16`: count of completed (PC-updating) instructions, saturating.

## Operation
- States:
  - IDLE: one cycle after reset; `mem_req=0`.
  - FETCH: `mem_req=1`, `mem_addr=pc`; wait for `mem_ack`.
  - EXEC: step counts 0→1→2→3.
  - HALTED: terminal.
- IDLE → FETCH unconditionally.
- FETCH behaviour:
  - Without `mem_ack`, the block stays in FETCH with address held; there is no timeout.
  - On `mem_ack`, `mem_rdata` is captured into `instrucao`, `step` is set to 0 and the state goes to EXEC.
- EXEC: `step` increments every cycle, 0..3.
- EXEC, step 3 with `pc_enable=1`:
  - `pc_load=0`: `pc <= pc+1`, wrapping mod 2^AW.
  - `pc_load=1`: `pc <= pc + sext(instrucao[9:0])` truncated to AW bits, wrapping mod 2^AW.
  - In both cases, `retired` increments (saturates at 16'hFFFF) and the state goes to FETCH.
- EXEC, step 3 with `pc_enable=0`: PC is unchanged and the state goes to FETCH. The same instruction address is refetched.
- `halt=1` in any EXEC cycle:
  - The state goes to HALTED next edge and `halted=1`.
  - `pc`, `instrucao` and `step` freeze at their current values.
  - `retired` is not incremented.
- HALTED is left only by reset. All inputs are ignored in HALTED.
- `mem_ack` outside FETCH is ignored; `instrucao` is unchanged.
- `halt`, `pc_enable` and `pc_load` are ignored outside EXEC.
- Branch offset field is `instrucao[9:0]`, a two's-complement signed value. Offset 0 loads the same PC, which is a legal self-loop.

## Timing
- Reset values, applied on an edge with `resetn=0`:
  - state IDLE
  - `pc=0`
  - `instrucao=16'h0000`
  - `step=0`
  - `mem_req=0`
  - `mem_addr=0`
  - `halted=0`
  - `retired=0`
- Reset mid-FETCH or mid-EXEC aborts the instruction. A `mem_ack` arriving in the IDLE cycle is discarded.
- `mem_req` and `mem_addr` are combinational from the registered state and PC, so they are glitch-free relative to `clk`.
- Fetch timing, with `mem_ack` in cycle N:
  - `instrucao` is valid and `step=0` in N+1.
  - `step=3` in N+4.
  - PC updates at the end of N+4.
  - `mem_req` is high with the new address in N+5.
- Minimum instruction period is 5 cycles (zero-wait memory). Each wait cycle in FETCH adds 1.
- `halt` is registered: with `halt` seen in cycle M, `halted=1` from M+1.
- `halt` and `pc_enable` high together at step 3: halt wins. There is no PC update and no retire.

## Test plan
- Reset then zero-wait memory returning ADD words (opcode 000) → `mem_addr` sequence 0,1,2; `step` cycles 0,1,2,3 between fetches; `retired=3` after third step 3.
- `mem_ack` delayed 3 cycles at `pc=5` → `mem_req` high 4 cycles with `mem_addr=5` throughout; the early stray `mem_ack` during EXEC does not change `instrucao`.
- At `pc=8`: BNE word with `instrucao[9:0]=10'h3FC` (−4), `pc_enable=1`, `pc_load=1` at step 3 → next `mem_addr=4`. At `pc=254` with `AW=8` and offset +3 → next address 1 (wrap).
- At `pc=255` with increment → next `mem_addr=0`; `retired` increments.
- HLT word fetched at `pc=6`, `halt=1` at step 0 → `halted=1` next cycle; `pc=6`, `step=0` frozen; `mem_req=0` thereafter despite `mem_ack` pulses.
- `resetn=0` during step 2 of an instruction at `pc=3` → next cycle `pc=0`, `step=0`, `instrucao=0`, `mem_req=0`, `halted=0`; first `mem_req` two cycles after `resetn` rises.
